// File: rtl/vmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vmem_arbiter_pkg
// Shared definitions for the scalar/vector data-memory arbiter:
//   - FSM state encodings (IDLE, OWN_S, OWN_V)
//   - owner identifiers (scalar / vector)
//   - default number of beats in one vector access
//   - packed request bundle used by the request mux
// ---------------------------------------------------------------------------
package vmem_arbiter_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_S = 2'd1;
    localparam logic [1:0] ST_OWN_V = 2'd2;

    // Owner identifiers, also the encoding of last_v
    localparam logic OWNER_S = 1'b0;
    localparam logic OWNER_V = 1'b1;

    // Two 32-bit beats make one 64-bit vector access
    localparam int VEC_BEATS_DEFAULT = 2;

    // One memory request as seen on the shared bus
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_req_t;

endpackage

// File: rtl/vmem_arbiter.sv
// ---------------------------------------------------------------------------
// vmem_arbiter
// Shares the single 32-bit data-memory bus between the scalar load/store path
// and the vector load/store unit. Ownership is granted round-robin from IDLE;
// the vector side keeps the bus for VEC_BEATS accepted beats so its two words
// are never split by scalar traffic. Only one read may be outstanding, and its
// response is routed to whichever side owns the bus.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   s_valid/s_write/s_addr/s_wdata/s_wmask   scalar request
//   s_ready                  scalar beat accepted this cycle
//   s_resp_valid/s_resp_rdata               scalar load response
//   v_valid/v_write/v_addr/v_wdata/v_wmask   vector request (from vlsu)
//   v_ready                  vector beat accepted this cycle
//   v_resp_valid/v_resp_rdata               vector load response
//   mem_valid/mem_write/mem_addr/mem_wdata/mem_wmask  memory request
//   mem_ready                memory accepts the presented beat
//   mem_resp_valid/mem_resp_rdata           memory read response
//   stray_resp               response arrived with no read outstanding
// ---------------------------------------------------------------------------
module vmem_arbiter
    import vmem_arbiter_pkg::*;
#(
    parameter int VEC_BEATS = VEC_BEATS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic        s_write,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wmask,
    output logic        s_ready,
    output logic        s_resp_valid,
    output logic [31:0] s_resp_rdata,
    input  logic        v_valid,
    input  logic        v_write,
    input  logic [31:0] v_addr,
    input  logic [31:0] v_wdata,
    input  logic [3:0]  v_wmask,
    output logic        v_ready,
    output logic        v_resp_valid,
    output logic [31:0] v_resp_rdata,
    output logic        mem_valid,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    output logic        stray_resp
);

    localparam int CW = $clog2(VEC_BEATS + 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          last_v;
    logic          last_v_nxt;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] beat_cnt_nxt;
    logic          rd_pend;
    logic          rd_pend_nxt;

    logic          own_s;
    logic          own_v;
    mem_req_t      sel;
    logic          sel_valid;
    logic [CW-1:0] beat_lim;
    logic          can_issue;
    logic          accept;
    logic          accept_rd;
    logic          resp_live;

    // Owner request mux, ready gating and response routing
    always_comb begin
        own_s     = (state == ST_OWN_S);
        own_v     = (state == ST_OWN_V);
        sel       = '0;
        sel_valid = 1'b0;
        beat_lim  = '0;
        if (own_s) begin
            sel.write = s_write;
            sel.addr  = s_addr;
            sel.wdata = s_wdata;
            sel.wmask = s_wmask;
            sel_valid = s_valid;
            beat_lim  = CW'(1);
        end else if (own_v) begin
            sel.write = v_write;
            sel.addr  = v_addr;
            sel.wdata = v_wdata;
            sel.wmask = v_wmask;
            sel_valid = v_valid;
            beat_lim  = CW'(VEC_BEATS);
        end else begin
            sel       = '0;
            sel_valid = 1'b0;
            beat_lim  = '0;
        end

        // A new beat may go out only when owned, no read is in flight and
        // the owner still has beats left in its access
        can_issue = (own_s | own_v) & ~rd_pend & (beat_cnt < beat_lim);

        mem_valid = sel_valid & can_issue;
        mem_write = sel.write;
        mem_addr  = sel.addr;
        mem_wdata = sel.wdata;
        mem_wmask = sel.wmask;

        s_ready   = mem_ready & can_issue & own_s;
        v_ready   = mem_ready & can_issue & own_v;

        accept    = mem_valid & mem_ready;
        accept_rd = accept & ~sel.write;

        // A response belongs to the owner if a read is pending or was
        // accepted in this very cycle (zero-latency memory)
        resp_live = mem_resp_valid & (own_s | own_v) & (rd_pend | accept_rd);

        s_resp_valid = resp_live & own_s;
        v_resp_valid = resp_live & own_v;
        s_resp_rdata = (resp_live & own_s) ? mem_resp_rdata : 32'h0000_0000;
        v_resp_rdata = (resp_live & own_v) ? mem_resp_rdata : 32'h0000_0000;

        stray_resp   = mem_resp_valid & ~resp_live & ~rst;
    end

    // Next-state: arbitration, beat counting, read tracking, release
    always_comb begin
        state_nxt    = state;
        last_v_nxt   = last_v;
        beat_cnt_nxt = accept ? (beat_cnt + CW'(1)) : beat_cnt;

        if (mem_resp_valid) begin
            rd_pend_nxt = 1'b0;
        end else if (accept_rd) begin
            rd_pend_nxt = 1'b1;
        end else begin
            rd_pend_nxt = rd_pend;
        end

        case (state)
            ST_IDLE: begin
                // Contention goes to the side not granted last time
                if (s_valid && (!v_valid || last_v)) begin
                    state_nxt    = ST_OWN_S;
                    last_v_nxt   = OWNER_S;
                    beat_cnt_nxt = '0;
                end else if (v_valid) begin
                    state_nxt    = ST_OWN_V;
                    last_v_nxt   = OWNER_V;
                    beat_cnt_nxt = '0;
                end else begin
                    state_nxt    = ST_IDLE;
                end
            end
            ST_OWN_S, ST_OWN_V: begin
                // Release once every beat is accepted and its data is back,
                // looking at next values so a same-cycle response counts
                if ((beat_cnt_nxt == beat_lim) && !rd_pend_nxt) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = state;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            last_v   <= OWNER_V;
            beat_cnt <= '0;
            rd_pend  <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_v   <= last_v_nxt;
            beat_cnt <= beat_cnt_nxt;
            rd_pend  <= rd_pend_nxt;
        end
    end

endmodule

// File: tb/tb_vmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vmem_arbiter
// Scoreboard bench for vmem_arbiter. Stimulus tasks push the expected beats,
// load data and grant order into queues; a monitor sampling on the falling
// edge pops and compares whenever the DUT accepts a beat, returns a response
// or flags a stray response. A small memory model answers reads with a
// programmable latency (0 = same cycle as acceptance).
// ---------------------------------------------------------------------------
module tb_vmem_arbiter;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        s_valid, s_write;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wmask;
    logic        s_ready, s_resp_valid;
    logic [31:0] s_resp_rdata;
    logic        v_valid, v_write;
    logic [31:0] v_addr, v_wdata;
    logic [3:0]  v_wmask;
    logic        v_ready, v_resp_valid;
    logic [31:0] v_resp_rdata;
    logic        mem_valid, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready, mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        stray_resp;

    beat_t       mq_s[$];
    beat_t       mq_v[$];
    logic [31:0] rq_s[$];
    logic [31:0] rq_v[$];
    logic        oq[$];
    bit          sq[$];

    int checks = 0;
    int errors = 0;

    int          mem_lat = 1;
    bit          inject_stray = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'h0;

    vmem_arbiter #(.VEC_BEATS(2)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wmask(s_wmask), .s_ready(s_ready),
        .s_resp_valid(s_resp_valid), .s_resp_rdata(s_resp_rdata),
        .v_valid(v_valid), .v_write(v_write), .v_addr(v_addr),
        .v_wdata(v_wdata), .v_wmask(v_wmask), .v_ready(v_ready),
        .v_resp_valid(v_resp_valid), .v_resp_rdata(v_resp_rdata),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .stray_resp(stray_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hA5A5, a[15:0]};
    endfunction

    // Memory model: answers each accepted read after mem_lat cycles
    initial begin
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            mem_resp_valid = 1'b0;
            mem_resp_rdata = 32'h0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = pend_data;
                end
            end else if (inject_stray) begin
                inject_stray   = 1'b0;
                mem_resp_valid = 1'b1;
                mem_resp_rdata = 32'h5757_5757;
            end else if (mem_valid && mem_ready && !mem_write) begin
                if (mem_lat == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = mem_word(mem_addr);
                end else begin
                    pend_cnt  = mem_lat;
                    pend_data = mem_word(mem_addr);
                end
            end
        end
    end

    // Monitor: compares every accepted beat, response and stray pulse
    initial begin
        beat_t       e;
        logic        ov;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (mem_valid && mem_ready) begin
                if (oq.size() == 0) begin
                    chk("beat_unexpected", 128'(1), 128'(0));
                end else begin
                    ov = oq.pop_front();
                    chk("beat_owner", 128'({s_ready, v_ready}), 128'({~ov, ov}));
                end
                if (v_ready) begin
                    if (mq_v.size() == 0) chk("v_beat_extra", 128'(1), 128'(0));
                    else begin
                        e = mq_v.pop_front();
                        chk("v_beat_fields", 128'({mem_write, mem_addr, mem_wdata, mem_wmask}), 128'(e));
                    end
                end else if (s_ready) begin
                    if (mq_s.size() == 0) chk("s_beat_extra", 128'(1), 128'(0));
                    else begin
                        e = mq_s.pop_front();
                        chk("s_beat_fields", 128'({mem_write, mem_addr, mem_wdata, mem_wmask}), 128'(e));
                    end
                end
            end
            if (v_resp_valid) begin
                if (rq_v.size() == 0) chk("v_resp_extra", 128'(1), 128'(0));
                else begin
                    d = rq_v.pop_front();
                    chk("v_resp", 128'({s_resp_valid, v_resp_valid, s_resp_rdata, v_resp_rdata}),
                        128'({1'b0, 1'b1, 32'h0, d}));
                end
            end else if (s_resp_valid) begin
                if (rq_s.size() == 0) chk("s_resp_extra", 128'(1), 128'(0));
                else begin
                    d = rq_s.pop_front();
                    chk("s_resp", 128'({s_resp_valid, v_resp_valid, s_resp_rdata, v_resp_rdata}),
                        128'({1'b1, 1'b0, d, 32'h0}));
                end
            end
            if (stray_resp) begin
                if (sq.size() == 0) chk("stray_extra", 128'(1), 128'(0));
                else begin
                    void'(sq.pop_front());
                    chk("stray_quiet", 128'({s_resp_valid, v_resp_valid, s_resp_rdata, v_resp_rdata}), 128'(0));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat_s(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic [31:0] rd);
        beat_t e;
        bit ok;
        e = '{w: w, a: a, d: d, m: m};
        mq_s.push_back(e);
        if (!w) rq_s.push_back(rd);
        s_valid = 1'b1; s_write = w; s_addr = a; s_wdata = d; s_wmask = m;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready;
        end
        chk("s_beat_handshake", 128'(ok), 128'(1));
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_write = 1'b0; s_addr = 32'h0; s_wdata = 32'h0; s_wmask = 4'h0;
    endtask

    task automatic beat_v(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic [31:0] rd);
        beat_t e;
        bit ok;
        e = '{w: w, a: a, d: d, m: m};
        mq_v.push_back(e);
        if (!w) rq_v.push_back(rd);
        v_valid = 1'b1; v_write = w; v_addr = a; v_wdata = d; v_wmask = m;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = v_ready;
        end
        chk("v_beat_handshake", 128'(ok), 128'(1));
        @(posedge clk);
        #1;
        v_valid = 1'b0; v_write = 1'b0; v_addr = 32'h0; v_wdata = 32'h0; v_wmask = 4'h0;
    endtask

    task automatic vec2(input logic w, input logic [31:0] a, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [31:0] rd0, input logic [31:0] rd1);
        beat_v(w, a, d0, w ? 4'hF : 4'h0, rd0);
        beat_v(w, a + 32'h4, d1, w ? 4'hF : 4'h0, rd1);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 128'({s_ready, s_resp_valid, s_resp_rdata, v_ready, v_resp_valid, v_resp_rdata, stray_resp}), 128'(0));
        chk(name, 128'({mem_valid, mem_write, mem_addr, mem_wdata, mem_wmask}), 128'(0));
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_write = 1'b0; s_addr = 32'h0; s_wdata = 32'h0; s_wmask = 4'h0;
        v_valid = 1'b0; v_write = 1'b0; v_addr = 32'h0; v_wdata = 32'h0; v_wmask = 4'h0;
        mem_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // Scalar write alone: bus mirrors scalar one cycle after request
        oq.push_back(1'b0);
        mq_s.push_back('{w: 1'b1, a: 32'h100, d: 32'hDEAD_BEEF, m: 4'hF});
        s_valid = 1'b1; s_write = 1'b1; s_addr = 32'h100; s_wdata = 32'hDEAD_BEEF; s_wmask = 4'hF;
        @(negedge clk);
        chk("request_cycle_idle", 128'({mem_valid, s_ready}), 128'(0));
        @(negedge clk);
        chk("grant_latency", 128'({mem_valid, mem_write, mem_addr, mem_wdata, s_ready, v_ready}),
            128'({1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0}));
        @(posedge clk); #1;
        s_valid = 1'b0; s_write = 1'b0; s_addr = 32'h0; s_wdata = 32'h0; s_wmask = 4'h0;
        @(negedge clk);
        chk("scalar_release", 128'({mem_valid, s_ready, v_ready}), 128'(0));
        idle(1);

        // Vector 64-bit load with 2-cycle memory; scalar waits for the lock
        mem_lat = 2;
        oq.push_back(1'b1); oq.push_back(1'b1); oq.push_back(1'b0);
        beat_v(1'b0, 32'h200, 32'h0, 4'h0, 32'hA5A5_0200);
        s_valid = 1'b1; s_write = 1'b0; s_addr = 32'h300; s_wdata = 32'h0; s_wmask = 4'h0;
        repeat (2) begin
            @(negedge clk);
            chk("lock_blocks_scalar", 128'({s_ready, mem_valid}), 128'(0));
        end
        beat_v(1'b0, 32'h204, 32'h0, 4'h0, 32'hA5A5_0204);
        beat_s(1'b0, 32'h300, 32'h0, 4'h0, 32'hA5A5_0300);
        idle(4);

        // Repeated contention alternates (last grant was scalar)
        oq.push_back(1'b1); oq.push_back(1'b1); oq.push_back(1'b0);
        oq.push_back(1'b1); oq.push_back(1'b1); oq.push_back(1'b0);
        fork
            begin
                beat_s(1'b1, 32'h710, 32'h0000_0A0A, 4'h3, 32'h0);
                beat_s(1'b1, 32'h714, 32'h0000_0B0B, 4'hC, 32'h0);
            end
            begin
                vec2(1'b1, 32'h800, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0);
                vec2(1'b1, 32'h808, 32'h3333_3333, 32'h4444_4444, 32'h0, 32'h0);
            end
        join
        idle(2);

        // Same-cycle read response
        mem_lat = 0;
        oq.push_back(1'b0);
        beat_s(1'b0, 32'h120, 32'h0, 4'h0, 32'hA5A5_0120);
        idle(2);

        // Response 3 cycles late: scalar keeps the bus, vector waits
        mem_lat = 3;
        oq.push_back(1'b0); oq.push_back(1'b1); oq.push_back(1'b1);
        fork
            beat_s(1'b0, 32'h140, 32'h0, 4'h0, 32'hA5A5_0140);
            begin
                @(posedge clk); #1;
                vec2(1'b0, 32'h500, 32'h0, 32'h0, 32'hA5A5_0500, 32'hA5A5_0504);
            end
        join
        idle(6);

        // Vector reads answered in the acceptance cycle
        mem_lat = 0;
        oq.push_back(1'b1); oq.push_back(1'b1);
        vec2(1'b0, 32'h580, 32'h0, 32'h0, 32'hA5A5_0580, 32'hA5A5_0584);
        idle(3);

        // Response with nothing outstanding while idle
        sq.push_back(1'b1);
        inject_stray = 1'b1;
        idle(3);

        // Reset between vector beats releases the bus at once
        mem_lat = 1;
        oq.push_back(1'b1);
        beat_v(1'b0, 32'h600, 32'h0, 4'h0, 32'hA5A5_0600);
        mem_ready = 1'b0;
        v_valid = 1'b1; v_write = 1'b0; v_addr = 32'h604;
        @(negedge clk);
        @(negedge clk);
        chk("vec_beat2_presented", 128'({mem_valid, mem_addr, v_ready}), 128'({1'b1, 32'h604, 1'b0}));
        #1 rst = 1'b1;
        #1;
        chk("reset_async_release", 128'({mem_valid, v_ready, s_ready}), 128'(0));
        v_valid = 1'b0; v_addr = 32'h0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk_all_zero("reset_hold_outputs");
        @(posedge clk); #1;
        rst = 1'b0;
        sq.push_back(1'b1);
        inject_stray = 1'b1;
        idle(3);

        // Contention out of reset: scalar first, then vector
        oq.push_back(1'b0); oq.push_back(1'b1); oq.push_back(1'b1);
        fork
            beat_s(1'b1, 32'h700, 32'h1234_5678, 4'hF, 32'h0);
            vec2(1'b1, 32'h900, 32'hCAFE_0000, 32'hCAFE_0001, 32'h0, 32'h0);
        join
        idle(4);

        chk("scoreboard_drained",
            128'({oq.size(), mq_s.size(), mq_v.size(), rq_s.size(), rq_v.size(), sq.size()}), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
